// File: rtl/phy_write_sequencer.sv
// phy_write_sequencer: collects one write burst, replays it gap-free into the
// PHY FIFO, then times tCWL and the DQ drive window. Option: WRSEQ_DM_EN.
module phy_write_sequencer #(
  parameter int PHY_CHANNEL   = 0,
  parameter int MEM_DATAWIDTH = 64,
  parameter int BURST_LENGTH  = 8,
  parameter int TCWL          = 12
) (
  input  logic                                    clk,
  input  logic                                    rst,
  output logic                                    wbReq,
  input  logic                                    wbValid,
  input  logic [MEM_DATAWIDTH-1:0]                wbData,
  input  logic [MEM_DATAWIDTH/BURST_LENGTH-1:0]   wbStrb,
  output logic                                    phyInflag,
  output logic [MEM_DATAWIDTH-1:0]                phyInData,
  output logic [MEM_DATAWIDTH/BURST_LENGTH-1:0]   phyInStrb,
  input  logic                                    wrCmdValid,
  output logic                                    wrCmdReady,
  output logic                                    phyOutflag,
  output logic                                    wrDone
);

  localparam int STRB_W = MEM_DATAWIDTH / BURST_LENGTH;
  localparam int BCW    = $clog2(BURST_LENGTH);
  localparam int LCW    = $clog2(TCWL + 1);
  localparam int DCW    = $clog2(BURST_LENGTH / 2 + 1);

  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LENGTH - 1);
  localparam logic [LCW-1:0] LAT_LOAD  = LCW'(TCWL - 1);
  localparam logic [DCW-1:0] DRV_LOAD  = DCW'(BURST_LENGTH / 2);

  typedef enum logic [2:0] {
    IDLE, FILL, PUSH, ARMED, WAIT_CWL, DRIVE
  } state_t;

  state_t state;
  state_t stateNext;

  logic [BCW-1:0] beatCnt;
  logic [BCW-1:0] nextBeat;
  logic [LCW-1:0] latCnt;
  logic [DCW-1:0] drvCnt;
  logic           capture;
  logic           accept;
  logic           lastBeat;
  logic [STRB_W-1:0] firstStrb;
  logic [STRB_W-1:0] nextStrb;
  logic [31:0]    unusedChan;

  logic [MEM_DATAWIDTH-1:0] dataBuf [BURST_LENGTH];

  assign unusedChan = PHY_CHANNEL;
  assign wbReq      = (state == FILL);
  assign wrCmdReady = (state == ARMED);
  assign capture    = wbReq & wbValid;
  assign accept     = wrCmdReady & wrCmdValid;
  assign nextBeat   = beatCnt + 1'b1;
  assign lastBeat   = (beatCnt == LAST_BEAT);

`ifdef WRSEQ_DM_EN
  logic [STRB_W-1:0] strbBuf [BURST_LENGTH];

  // capture per-beat strobes alongside the data
  always_ff @(posedge clk) begin
    if (capture) strbBuf[beatCnt] <= wbStrb;
  end

  assign firstStrb = strbBuf[0];
  assign nextStrb  = strbBuf[nextBeat];
`else
  logic unusedStrb;
  assign unusedStrb = ^wbStrb;
  assign firstStrb  = '1;
  assign nextStrb   = '1;
`endif

  // beat storage; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (capture) dataBuf[beatCnt] <= wbData;
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // next-state decode
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:     stateNext = FILL;
      FILL:     if (capture && lastBeat) stateNext = PUSH;
      PUSH:     if (lastBeat) stateNext = ARMED;
      ARMED:    if (accept) stateNext = (TCWL == 1) ? DRIVE : WAIT_CWL;
      WAIT_CWL: if (latCnt == LCW'(1)) stateNext = DRIVE;
      DRIVE:    if (drvCnt == '0) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // counters and registered PHY-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beatCnt    <= '0;
      latCnt     <= '0;
      drvCnt     <= '0;
      phyInflag  <= 1'b0;
      phyInData  <= '0;
      phyInStrb  <= '0;
      phyOutflag <= 1'b0;
      wrDone     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          beatCnt <= '0;
          wrDone  <= 1'b0;
        end
        FILL: begin
          if (capture) begin
            beatCnt <= nextBeat;
            if (lastBeat) begin
              phyInflag <= 1'b1;
              phyInData <= dataBuf[0];
              phyInStrb <= firstStrb;
            end
          end
        end
        PUSH: begin
          beatCnt <= nextBeat;
          if (lastBeat) begin
            phyInflag <= 1'b0;
            phyInData <= '0;
            phyInStrb <= '0;
          end else begin
            phyInData <= dataBuf[nextBeat];
            phyInStrb <= nextStrb;
          end
        end
        ARMED: begin
          if (accept) begin
            latCnt <= LAT_LOAD;
            if (TCWL == 1) begin
              drvCnt     <= DRV_LOAD;
              phyOutflag <= 1'b1;
            end
          end
        end
        WAIT_CWL: begin
          latCnt <= latCnt - 1'b1;
          if (latCnt == LCW'(1)) begin
            drvCnt     <= DRV_LOAD;
            phyOutflag <= 1'b1;
          end
        end
        DRIVE: begin
          if (drvCnt != '0) begin
            drvCnt <= drvCnt - 1'b1;
            if (drvCnt == DCW'(1)) begin
              phyOutflag <= 1'b0;
              wrDone     <= 1'b1;
            end
          end else begin
            wrDone <= 1'b0;
          end
        end
        default: begin
          wrDone <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/phy_write_sequencer.md
# phy_write_sequencer

Per-channel WRITE data sequencer that sits directly upstream of the PHY write-mode data path. It collects one burst of beats from the channel Write Buffer and replays it as a contiguous, gap-free fill stream into the PHY write FIFO. It then holds the burst until the WRITE command is accepted, counts out tCWL, and opens the DRAM drive window (`phyOutflag`) for exactly one burst.

## Interface
Parameters:
- `PHY_CHANNEL`, default 0: channel index; display only.
- `MEM_DATAWIDTH`, default 64: DQ beat width.
- `BURST_LENGTH`, default 8: beats per burst; power of two, ≥2.
- `TCWL`, default 12: CAS write latency in clk cycles; legal range ≥1.

Ports:
- `clk`, input, 1: single clock.
- `rst`, input, 1: reset. Asynchronous, active-high.
- `wbReq`, output, 1: requesting a beat from the Write Buffer.
- `wbValid`, input, 1: Write Buffer beat valid.
- `wbData`, input, MEM_DATAWIDTH: beat data.
- `wbStrb`, input, MEM_DATAWIDTH/BURST_LENGTH: beat byte strobes.
- `phyInflag`, output, 1: PHY FIFO push valid.
- `phyInData`, output, MEM_DATAWIDTH: PHY FIFO push data.
- `phyInStrb`, output, MEM_DATAWIDTH/BURST_LENGTH: PHY FIFO push strobes.
- `wrCmdValid`, input, 1: WRITE command issued to DRAM.
- `wrCmdReady`, output, 1: burst staged in PHY; command may be accepted.
- `phyOutflag`, output, 1: PHY allowed to drive DQ/DQS.
- `wrDone`, output, 1: one-cycle pulse, burst completed.

## Operation
- States: `IDLE`, `FILL`, `PUSH`, `ARMED`, `WAIT_CWL`, `DRIVE`.
- `IDLE` transitions unconditionally to `FILL` on the next edge.
- `FILL`:
  - `wbReq=1`, decoded combinationally from state.
  - A beat is captured into local buffer slot `beatCnt` at each edge where `wbReq && wbValid`. Gaps in `wbValid` are tolerated.
  - The edge that captures beat BURST_LENGTH−1 moves the block to `PUSH` and clears `beatCnt`.
- `PUSH`:
  - Registered outputs: `phyInflag=1` with `phyInData`/`phyInStrb` carrying local beat i in PUSH cycle i.
  - Exactly BURST_LENGTH consecutive cycles, beat 0 first, no gaps. The downstream FIFO pointer restarts whenever `phyInflag` drops, so the stream must be contiguous.
  - Then `ARMED`.
- `ARMED`:
  - `wrCmdReady=1`, decoded combinationally from state.
  - Accept occurs at an edge where `wrCmdValid && wrCmdReady`. On accept the block loads the latency counter and enters `WAIT_CWL`, or `DRIVE` directly if TCWL==1.
- `WAIT_CWL` counts down, then enters `DRIVE`.
- `DRIVE`:
  - `phyOutflag=1` (registered) for BURST_LENGTH/2 clk cycles, i.e. BURST_LENGTH clk2x beats downstream.
  - The final edge sets `wrDone=1` for one cycle and returns to `IDLE`.
- Ignored inputs:
  - `wrCmdValid` outside `ARMED`: no accept, no state change.
  - `wbValid` outside `FILL`: no capture.
- Counter widths:
  - `beatCnt` is $clog2(BURST_LENGTH) bits and wraps to 0 after BURST_LENGTH−1.
  - The latency counter is $clog2(TCWL+1) bits and the drive counter is $clog2(BURST_LENGTH/2+1) bits. Neither may overflow.

## Timing
- Reset values: `wbReq`, `phyInflag`, `phyOutflag`, `wrCmdReady`, `wrDone` are all 0; `phyInData` and `phyInStrb` are 0; state `IDLE`; all counters 0. The local beat buffer is not cleared.
- `rst` asserted mid-operation forces every output to its reset value immediately (asynchronous), and abandons any partial burst. After release the block restarts at `IDLE` and refills from beat 0.
- Command latency: with the accept edge at cycle t, `phyOutflag` is high during cycles t+TCWL … t+TCWL+BURST_LENGTH/2−1.
- `wrDone` is high in cycle t+TCWL+BURST_LENGTH/2.
- `wbReq` next rises 2 cycles after `wrDone`.
- Fill: the minimum is BURST_LENGTH cycles with `wbValid` held high. `phyInflag` rises on the cycle after the last beat is captured.
- `wrCmdReady` rises the cycle after the last `phyInflag` cycle.
- Only one burst is in flight at a time. No fill of the next burst overlaps `ARMED`, `WAIT_CWL` or `DRIVE`.

## Configuration
- `WRSEQ_DM_EN`:
  - Defined: `wbStrb` is captured per beat and forwarded on `phyInStrb`.
  - Undefined: `wbStrb` is ignored and not stored. `phyInStrb` is driven all-ones during `PUSH` (no masking) and 0 otherwise.

## Test plan
- Reset, then 8 beats 0x1000…0x1007 with `wbValid` held high: `phyInflag` is high for exactly 8 consecutive cycles carrying 0x1000…0x1007 in order, then `wrCmdReady=1`.
- Beats with a 3-cycle `wbValid` gap after beat 2: the `PUSH` stream is still 8 contiguous cycles in order, with no early `phyInflag`.
- TCWL=12, accept at cycle t: `phyOutflag` is high in cycles t+12…t+15, `wrDone` pulses in cycle t+16, and `wbReq` rises in cycle t+18.
- `wrCmdValid` pulsed during `FILL` and `PUSH`: no accept, `phyOutflag` stays 0, and the command is accepted only once `ARMED` is reached.
- `rst` asserted in `WAIT_CWL` and in `DRIVE`: all outputs are 0 in the same cycle, and after release a fresh 8-beat fill completes normally.
- `WRSEQ_DM_EN` defined with `wbStrb`=0xA5 on beat 3: beat 3 of the push carries 0xA5. With the macro undefined, every push beat carries 0xFF.
